// File: rtl/pool_pkg.sv
// Shared constants and state encoding for the first pooling-layer controller.
// Latency: none (package only).
// Backpressure: none (package only).
package pool_pkg;

  localparam int CH_DEF      = 18;
  localparam int IN_DIM_DEF  = 24;
  localparam int OUT_DIM_DEF = IN_DIM_DEF / 2;
  localparam int RD_AW_DEF   = $clog2(CH_DEF * IN_DIM_DEF);
  localparam int WR_AW_DEF   = $clog2(CH_DEF * OUT_DIM_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_EVEN,
    S_RD_ODD,
    S_WR,
    S_DONE
  } pool_state_t;

  // Counter width that stays legal when the counted range collapses to one value.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pool_pair_or.sv
// Binary 2x2 max-pool of one row pair: OR of each 2-pixel column pair across both rows.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module pool_pair_or #(
  parameter  int IN_W  = 24,
  localparam int OUT_W = IN_W / 2
) (
  input  logic [0:IN_W-1]  even_row,
  input  logic [0:IN_W-1]  odd_row,
  output logic [0:OUT_W-1] pooled
);

  // Each output pixel covers input columns 2j and 2j+1 of both rows.
  always_comb begin
    pooled = '0;
    for (int j = 0; j < OUT_W; j++) begin
      pooled[j] = even_row[2*j] | even_row[2*j+1] | odd_row[2*j] | odd_row[2*j+1];
    end
  end

endmodule

// File: rtl/pool1_ctrl.sv
// Sequences a full 2x2 binary max-pool pass: two row reads, one pooled row write, per output row.
// Latency: 3 cycles per output row with wr_ready high; done 3*CH*OUT_DIM+1 cycles after start.
// Backpressure: wr_ready low holds the write (address/data stable) and issues no reads.
module pool1_ctrl
  import pool_pkg::*;
#(
  parameter  int CH      = CH_DEF,
  parameter  int IN_DIM  = IN_DIM_DEF,
  localparam int OUT_DIM = IN_DIM / 2,
  localparam int RD_AW   = $clog2(CH * IN_DIM),
  localparam int WR_AW   = $clog2(CH * OUT_DIM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [RD_AW-1:0]   rd_addr,
  input  logic [0:IN_DIM-1]  rd_data,
  output logic               wr_en,
  input  logic               wr_ready,
  output logic [WR_AW-1:0]   wr_addr,
  output logic [0:OUT_DIM-1] wr_data
);

  localparam int CHW = clog2_min1(CH);
  localparam int ORW = clog2_min1(OUT_DIM);

  pool_state_t       state;
  logic [CHW-1:0]    ch;
  logic [ORW-1:0]    orow;
  logic [0:IN_DIM-1] row_buf;   // even input row
  logic [0:IN_DIM-1] odd_buf;   // odd input row, held across write stalls
  logic              wr_fresh;  // first WR cycle: odd row is still on rd_data
  logic [0:IN_DIM-1] odd_row;
  logic [0:OUT_DIM-1] pooled;

  function automatic logic [RD_AW-1:0] rd_row_addr(input int c, input int r);
    return RD_AW'(c * IN_DIM + 2 * r);
  endfunction

  function automatic logic [WR_AW-1:0] wr_row_addr(input int c, input int r);
    return WR_AW'(c * OUT_DIM + r);
  endfunction

  // The odd row arrives on rd_data in the first WR cycle and is replayed from odd_buf while stalled.
  assign odd_row = wr_fresh ? rd_data : odd_buf;

  pool_pair_or #(.IN_W(IN_DIM)) u_pair_or (
    .even_row (row_buf),
    .odd_row  (odd_row),
    .pooled   (pooled)
  );

  assign wr_data = wr_en ? pooled : '0;

  // Pass sequencer: state, row/channel counters and registered strobes/addresses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ch       <= '0;
      orow     <= '0;
      row_buf  <= '0;
      odd_buf  <= '0;
      wr_fresh <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RD_EVEN;
            ch      <= '0;
            orow    <= '0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        S_RD_EVEN: begin
          state   <= S_RD_ODD;
          rd_en   <= 1'b1;
          rd_addr <= rd_addr + RD_AW'(1);
        end
        S_RD_ODD: begin
          row_buf  <= rd_data;
          state    <= S_WR;
          rd_en    <= 1'b0;
          rd_addr  <= '0;
          wr_en    <= 1'b1;
          wr_addr  <= wr_row_addr(int'(ch), int'(orow));
          wr_fresh <= 1'b1;
        end
        S_WR: begin
          if (wr_fresh) begin
            odd_buf <= rd_data;
          end
          wr_fresh <= 1'b0;
          if (wr_ready) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            if (int'(orow) < OUT_DIM - 1) begin
              orow    <= orow + ORW'(1);
              state   <= S_RD_EVEN;
              rd_en   <= 1'b1;
              rd_addr <= rd_row_addr(int'(ch), int'(orow) + 1);
            end else begin
              orow <= '0;
              if (int'(ch) < CH - 1) begin
                ch      <= ch + CHW'(1);
                state   <= S_RD_EVEN;
                rd_en   <= 1'b1;
                rd_addr <= rd_row_addr(int'(ch) + 1, 0);
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          rd_en <= 1'b0;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool1_ctrl.sv
// Randomized bench for pool1_ctrl against a row-level 2x2 OR reference over a memory image.
// Latency: checks 3-cycle row cadence and done at cycle 649 with wr_ready held high.
// Backpressure: random wr_ready; checks stable write and no reads while stalled.
module tb_pool1_ctrl;

  localparam int CH      = 18;
  localparam int IN_DIM  = 24;
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int N_RD    = CH * IN_DIM;
  localparam int N_WR    = CH * OUT_DIM;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [8:0]         rd_addr;
  logic [0:IN_DIM-1]  rd_data;
  logic               wr_en;
  logic               wr_ready;
  logic [7:0]         wr_addr;
  logic [0:OUT_DIM-1] wr_data;

  pool1_ctrl #(.CH(CH), .IN_DIM(IN_DIM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Input memory image and its read port: data one cycle after rd_en, junk otherwise.
  logic [0:IN_DIM-1] mem [0:N_RD-1];
  always @(posedge clk) begin
    rd_data <= rd_en ? mem[rd_addr] : IN_DIM'($urandom);
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference: k-th read targets channel k/24, row pair of output row (k/2)%12.
  function automatic int exp_rd(input int k);
    int p = k / 2;
    return (p / OUT_DIM) * IN_DIM + 2 * (p % OUT_DIM) + (k % 2);
  endfunction

  // Reference: k-th write is output row k%12 of channel k/12, OR over each 2x2 window.
  function automatic logic [0:OUT_DIM-1] exp_wr(input int k);
    logic [0:IN_DIM-1]  e;
    logic [0:IN_DIM-1]  o;
    logic [0:OUT_DIM-1] res;
    int c = k / OUT_DIM;
    int r = k % OUT_DIM;
    e = mem[c * IN_DIM + 2 * r];
    o = mem[c * IN_DIM + 2 * r + 1];
    for (int j = 0; j < OUT_DIM; j++) res[j] = e[2*j] | e[2*j+1] | o[2*j] | o[2*j+1];
    return res;
  endfunction

  // Controls written by the stimulus process.
  bit mon_on    = 1'b0;
  bit rnd_ready = 1'b0;
  int clr_seq   = 0;
  int accept_edge = 0;

  // Scoreboard state owned by the monitor.
  int clr_seen = 0;
  int wr_idx = 0;
  int rd_idx = 0;
  int busy_cnt = 0;
  int nz_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit stalled = 1'b0;
  logic [7:0]         prev_addr;
  logic [0:OUT_DIM-1] prev_dat;
  logic [0:OUT_DIM-1] cap65;

  // Monitor: drives wr_ready for the coming edge, then checks everything visible this cycle.
  always @(negedge clk) begin
    wr_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      wr_idx = 0; rd_idx = 0; busy_cnt = 0; nz_cnt = 0; stalled = 1'b0;
      cap65 = '1;
    end
    if (mon_on) begin
      if (busy) busy_cnt++;
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(exp_rd(rd_idx)));
        rd_idx++;
      end else begin
        chk("rd_addr_idle", 32'(rd_addr), 0);
      end
      if (wr_en) begin
        chk("rd_in_wr", 32'(rd_en), 0);
        if (stalled) begin
          chk("stall_addr", 32'(wr_addr), 32'(prev_addr));
          chk("stall_dat", 32'(wr_data), 32'(prev_dat));
        end
        chk("wr_addr", 32'(wr_addr), 32'(wr_idx));
        chk("wr_dat", 32'(wr_data), 32'(exp_wr(wr_idx)));
        prev_addr = wr_addr;
        prev_dat  = wr_data;
        if (wr_ready) begin
          if (wr_data != '0) nz_cnt++;
          if (wr_addr == 8'd65) cap65 = wr_data;
          wr_idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
      end else begin
        chk("wr_addr_idle", 32'(wr_addr), 0);
        chk("wr_dat_idle", 32'(wr_data), 0);
        stalled = 1'b0;
      end
      if (done) begin
        chk("done_busy", 32'(busy), 1);
        chk("wr_count", 32'(wr_idx), N_WR);
        chk("rd_count", 32'(rd_idx), N_RD);
        done_cyc = edge_cnt - accept_edge + 1;
        done_cnt++;
        wr_idx = 0;
        rd_idx = 0;
      end
    end
  end

  task automatic start_pass(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    accept_edge = edge_cnt;
    clr_seq++;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
  endtask

  initial begin
    int d0;
    bit hit;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < N_RD; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    mon_on = 1'b1;

    // All-zero memory, wr_ready held high: timing and address order.
    rnd_ready = 1'b0;
    start_pass(1'b0);
    wait_done("t1_done_seen");
    repeat (2) @(negedge clk);
    chk("t1_done_cycle", 32'(done_cyc), 649);
    chk("t1_busy_cycles", 32'(busy_cnt), 649);
    chk("t1_nonzero", 32'(nz_cnt), 0);

    // Single pixel: channel 5 row 11 pixel 7 lands in write 65, output pixel 3.
    mem[5 * IN_DIM + 11][7] = 1'b1;
    start_pass(1'b0);
    wait_done("t2_done_seen");
    repeat (2) @(negedge clk);
    chk("t2_cap65", 32'(cap65), 32'(12'b0001_0000_0000));
    chk("t2_nonzero", 32'(nz_cnt), 1);
    chk("t2_done_cycle", 32'(done_cyc), 649);

    // Random memory with random write backpressure.
    for (int i = 0; i < N_RD; i++) mem[i] = IN_DIM'($urandom);
    rnd_ready = 1'b1;
    start_pass(1'b0);
    wait_done("t3_done_seen");
    repeat (2) @(negedge clk);

    // Reset in the middle of channel 9's write: outputs clear, no done, clean restart.
    d0 = done_cnt;
    start_pass(1'b0);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (wr_en && wr_addr >= 8'd108) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t4_reached_ch9", 32'(hit), 1);
    chk("t4_addr_ch9", 32'(wr_addr / 12), 9);
    mon_on = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("t4_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_no_done", 32'(done), 0);
      chk("t4_idle_busy", 32'(busy), 0);
    end
    chk("t4_done_cnt_abort", 32'(done_cnt - d0), 0);
    clr_seq++;
    @(negedge clk);
    mon_on = 1'b1;
    start_pass(1'b0);
    wait_done("t4_done_seen");
    repeat (2) @(negedge clk);
    chk("t4_done_cnt", 32'(done_cnt - d0), 1);

    // Start held high: one IDLE cycle between DONE and the next pass.
    rnd_ready = 1'b0;
    d0 = done_cnt;
    start_pass(1'b1);
    wait_done("t5_done1_seen");
    @(negedge clk);
    chk("t5_gap_busy", 32'(busy), 0);
    chk("t5_gap_rd_en", 32'(rd_en), 0);
    @(negedge clk);
    chk("t5_restart_rd_en", 32'(rd_en), 1);
    chk("t5_restart_rd_addr", 32'(rd_addr), 0);
    chk("t5_restart_busy", 32'(busy), 1);
    wait_done("t5_done2_seen");
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_final_busy", 32'(busy), 0);
    chk("t5_done_cnt", 32'(done_cnt - d0), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
